// File: rtl/splash_sequencer_pkg.sv
// Shared definitions for the end-of-game splash sequencer and the splash draw modules.
package splash_sequencer_pkg;

  localparam int VGA_W = 10;

  // Frame start is the scan position where both counters sit at the origin.
  localparam logic [VGA_W-1:0] VERT_ORIGIN = '0;
  localparam logic [VGA_W-1:0] HORZ_ORIGIN = '0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_BLINK = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } splash_state_t;

  function automatic int cnt_w(input int max_val);
    return (max_val <= 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/splash_sequencer_if.sv
// Game-side and draw-side signals of the splash sequencer.
interface splash_sequencer_if;
  import splash_sequencer_pkg::*;

  logic [VGA_W-1:0] vert;
  logic [VGA_W-1:0] horz;
  logic             win;
  logic             lose;
  logic             btn_restart;
  logic             show_success;
  logic             show_fail;
  logic             restart;
  logic             busy;

  modport master (
    output vert, horz, win, lose, btn_restart,
    input  show_success, show_fail, restart, busy
  );

  modport slave (
    input  vert, horz, win, lose, btn_restart,
    output show_success, show_fail, restart, busy
  );

endinterface

// File: rtl/splash_sequencer_frame_tick_gen.sv
// One-clock frame_tick on the first clk of each frame, however long the VGA origin is held.
module frame_tick_gen
  import splash_sequencer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [VGA_W-1:0] vert,
  input  logic [VGA_W-1:0] horz,
  output logic             frame_tick
);

  logic fstart;
  logic fstart_q;

  assign fstart = (vert == VERT_ORIGIN) && (horz == HORZ_ORIGIN);

  always_ff @(posedge clk) begin
    if (reset) fstart_q <= 1'b0;
    else       fstart_q <= fstart;
  end

  assign frame_tick = fstart & ~fstart_q;

endmodule

// File: rtl/splash_sequencer.sv
// Latches win/lose, starts the splash on a frame boundary, blinks it, holds it and
// issues a one-cycle restart pulse on a fresh button press.
module splash_sequencer
  import splash_sequencer_pkg::*;
#(
  parameter int BLINK_FRAMES    = 15,
  parameter int BLINK_TOGGLES   = 6,
  parameter int HOLD_MIN_FRAMES = 60
) (
  input logic               clk,
  input logic               reset,
  splash_sequencer_if.slave bus
);

  localparam int FCNT_MAX = (BLINK_FRAMES > HOLD_MIN_FRAMES) ? BLINK_FRAMES : HOLD_MIN_FRAMES;
  localparam int FCNT_W   = cnt_w(FCNT_MAX);
  localparam int TCNT_W   = cnt_w(BLINK_TOGGLES);

  localparam logic [FCNT_W-1:0] BLINK_LAST  = FCNT_W'(BLINK_FRAMES - 1);
  localparam logic [FCNT_W-1:0] HOLD_SAT    = FCNT_W'(HOLD_MIN_FRAMES);
  localparam logic [TCNT_W-1:0] TOGGLE_LAST = TCNT_W'(BLINK_TOGGLES - 1);

  splash_state_t     state, state_nxt;
  logic [FCNT_W-1:0] frame_cnt, frame_cnt_nxt;
  logic [TCNT_W-1:0] toggle_cnt, toggle_cnt_nxt;
  logic              visible, visible_nxt;
  logic              is_win, is_win_nxt;
  logic              btn_q;
  logic              btn_rise;
  logic              frame_tick;
  logic              splash_on;
  logic              show_success_d, show_fail_d, restart_d, busy_d;

  frame_tick_gen u_frame_tick_gen (
    .clk        (clk),
    .reset      (reset),
    .vert       (bus.vert),
    .horz       (bus.horz),
    .frame_tick (frame_tick)
  );

  assign btn_rise = bus.btn_restart & ~btn_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      frame_cnt  <= '0;
      toggle_cnt <= '0;
      visible    <= 1'b0;
      is_win     <= 1'b0;
      btn_q      <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_cnt  <= frame_cnt_nxt;
      toggle_cnt <= toggle_cnt_nxt;
      visible    <= visible_nxt;
      is_win     <= is_win_nxt;
      btn_q      <= bus.btn_restart;
    end
  end

  always_comb begin
    state_nxt      = state;
    frame_cnt_nxt  = frame_cnt;
    toggle_cnt_nxt = toggle_cnt;
    visible_nxt    = visible;
    is_win_nxt     = is_win;
    case (state)
      ST_IDLE: begin
        if (bus.win || bus.lose) begin
          state_nxt  = ST_ARM;
          is_win_nxt = bus.win;
        end
      end
      ST_ARM: begin
        if (frame_tick) begin
          state_nxt      = ST_BLINK;
          visible_nxt    = 1'b1;
          frame_cnt_nxt  = '0;
          toggle_cnt_nxt = '0;
        end
      end
      ST_BLINK: begin
        if (frame_tick) begin
          if (frame_cnt == BLINK_LAST) begin
            frame_cnt_nxt  = '0;
            visible_nxt    = ~visible;
            toggle_cnt_nxt = toggle_cnt + TCNT_W'(1);
            // Final toggle lands visible because the toggle count is even.
            if (toggle_cnt == TOGGLE_LAST) begin
              state_nxt   = ST_HOLD;
              visible_nxt = 1'b1;
            end
          end else begin
            frame_cnt_nxt = frame_cnt + FCNT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        visible_nxt = 1'b1;
        if (frame_tick && (frame_cnt != HOLD_SAT)) frame_cnt_nxt = frame_cnt + FCNT_W'(1);
        if (btn_rise && (frame_cnt == HOLD_SAT)) state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    splash_on      = (state == ST_BLINK) || (state == ST_HOLD);
    show_success_d = visible & is_win & splash_on;
    show_fail_d    = visible & ~is_win & splash_on;
    restart_d      = (state == ST_DONE);
    busy_d         = (state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.show_success <= 1'b0;
      bus.show_fail    <= 1'b0;
      bus.restart      <= 1'b0;
      bus.busy         <= 1'b0;
    end else begin
      bus.show_success <= show_success_d;
      bus.show_fail    <= show_fail_d;
      bus.restart      <= restart_d;
      bus.busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_splash_sequencer.sv
// Bench for splash_sequencer: a small VGA raster, a frame-count reference model, vector table and scenarios.
module tb_splash_sequencer;
  import splash_sequencer_pkg::*;

  localparam int BF        = 2;
  localparam int BT        = 4;
  localparam int HM        = 3;
  localparam int PIX_CLK   = 4;
  localparam int H_TOT     = 8;
  localparam int V_TOT     = 4;
  localparam int FRAME_LEN = H_TOT * V_TOT * PIX_CLK;

  logic clk = 1'b0;
  logic reset = 1'b1;

  splash_sequencer_if bus();

  splash_sequencer #(
    .BLINK_FRAMES    (BF),
    .BLINK_TOGGLES   (BT),
    .HOLD_MIN_FRAMES (HM)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int hpos = 0, vpos = 0, pix_cnt = 0;
  bit vga_run = 1'b0;
  bit stretch = 1'b0;

  typedef enum int {M_IDLE, M_WAIT, M_SPLASH, M_DONE} mode_t;
  mode_t m_mode = M_IDLE;
  bit    m_win = 1'b0;
  int    m_frames = 0;
  bit    m_fs_prev = 1'b0, m_btn_prev = 1'b0;
  bit    e_ss = 1'b0, e_sf = 1'b0, e_rs = 1'b0, e_busy = 1'b0;

  int rise_cyc = -1, fall_cyc = -1;
  int rs_pulses = 0, sf_high = 0, ss_high = 0;
  bit any_prev = 1'b0;

  typedef struct {
    bit rst, w, l, b;
    bit busy, ss, sf, rs;
  } vec_t;
  vec_t tbl[11];

  function automatic bit model_visible(input int frames);
    if (frames < BF * BT) return ((frames / BF) % 2) == 0;
    return 1'b1;
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0b expected=%0b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Outputs after an edge reflect the model state held before that edge.
  task automatic model_edge();
    bit fs, tick, rise;
    if (reset) begin
      {e_ss, e_sf, e_rs, e_busy} = 4'b0;
      m_mode = M_IDLE; m_win = 1'b0; m_frames = 0;
      m_fs_prev = 1'b0; m_btn_prev = 1'b0;
      return;
    end
    e_busy = (m_mode != M_IDLE);
    e_rs   = (m_mode == M_DONE);
    e_ss   = (m_mode == M_SPLASH) && model_visible(m_frames) && m_win;
    e_sf   = (m_mode == M_SPLASH) && model_visible(m_frames) && !m_win;
    fs   = (bus.vert == 0) && (bus.horz == 0);
    tick = fs && !m_fs_prev;
    rise = bus.btn_restart && !m_btn_prev;
    m_fs_prev  = fs;
    m_btn_prev = bus.btn_restart;
    case (m_mode)
      M_IDLE: if (bus.win || bus.lose) begin m_mode = M_WAIT; m_win = bus.win; end
      M_WAIT: if (tick) begin m_mode = M_SPLASH; m_frames = 0; end
      M_SPLASH: begin
        if ((m_frames >= BF * BT + HM) && rise) m_mode = M_DONE;
        if (tick && m_frames < 1000) m_frames++;
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  task automatic cycle();
    bit any;
    int dur;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    check1("busy", bus.busy, e_busy);
    check1("show_success", bus.show_success, e_ss);
    check1("show_fail", bus.show_fail, e_sf);
    check1("restart", bus.restart, e_rs);
    if (bus.restart) rs_pulses++;
    if (bus.show_fail) sf_high++;
    if (bus.show_success) ss_high++;
    any = bus.show_success | bus.show_fail;
    if (any && !any_prev && rise_cyc < 0) rise_cyc = cyc;
    else if (!any && any_prev && rise_cyc >= 0 && fall_cyc < 0) fall_cyc = cyc;
    any_prev = any;
    if (vga_run) begin
      dur = (stretch && hpos == 0 && vpos == 0) ? 2 * PIX_CLK : PIX_CLK;
      pix_cnt++;
      if (pix_cnt >= dur) begin
        pix_cnt = 0;
        hpos++;
        if (hpos == H_TOT) begin hpos = 0; vpos = (vpos + 1) % V_TOT; end
      end
    end
    bus.vert = 10'(vpos);
    bus.horz = 10'(hpos);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic clear_stats();
    rise_cyc = -1; fall_cyc = -1;
    rs_pulses = 0; sf_high = 0; ss_high = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1; cycle(); reset = 1'b0;
  endtask

  task automatic pulse(input bit w, input bit l);
    bus.win = w; bus.lose = l; cycle();
    bus.win = 1'b0; bus.lose = 1'b0;
  endtask

  task automatic run_until_frames(input int f, input string name);
    int budget;
    budget = (f + 3) * (FRAME_LEN + 2 * PIX_CLK);
    while (!(m_mode == M_SPLASH && m_frames >= f) && budget > 0) begin
      cycle();
      budget--;
    end
    if (budget == 0) begin
      checks++; errors++;
      $display("FAIL %s timeout waiting for frame %0d", name, f);
    end
  endtask

  task automatic press_restart();
    bus.btn_restart = 1'b1; run(6);
    bus.btn_restart = 1'b0; run(4);
  endtask

  initial begin
    bus.vert = 10'd5; bus.horz = 10'd3;
    bus.win = 1'b0; bus.lose = 1'b0; bus.btn_restart = 1'b0;

    // VGA parked off-origin: no frame_tick, so ARM persists.
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 1, 0, 0, 0};
    tbl[4]  = '{0, 0, 1, 0, 1, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 1, 1, 0, 0, 0};
    tbl[6]  = '{1, 0, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{0, 1, 1, 0, 0, 0, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 1, 0, 0, 0};
    tbl[9]  = '{1, 0, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 11; i++) begin
      reset = tbl[i].rst; bus.win = tbl[i].w; bus.lose = tbl[i].l; bus.btn_restart = tbl[i].b;
      cycle();
      check1($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].busy);
      check1($sformatf("tbl%0d_ss", i), bus.show_success, tbl[i].ss);
      check1($sformatf("tbl%0d_sf", i), bus.show_fail, tbl[i].sf);
      check1($sformatf("tbl%0d_rs", i), bus.restart, tbl[i].rs);
    end
    reset = 1'b0; bus.win = 1'b0; bus.lose = 1'b0; bus.btn_restart = 1'b0;

    // Scenario 1: win mid-frame, blink timing, steady hold.
    vpos = 2; hpos = 3; pix_cnt = 0; vga_run = 1'b1;
    do_reset(); clear_stats();
    pulse(1'b1, 1'b0);
    run_until_frames(BF * BT + 1, "s1");
    run(FRAME_LEN);
    check_int("s1_fail_never", sf_high, 0);
    check_int("s1_first_on_len", fall_cyc - rise_cyc, BF * FRAME_LEN);
    check1("s1_steady_on", bus.show_success, 1'b1);
    check_int("s1_no_restart", rs_pulses, 0);

    // Scenario 2: simultaneous win/lose, then a stray lose during blink.
    do_reset(); clear_stats();
    pulse(1'b1, 1'b1);
    run_until_frames(2, "s2a");
    pulse(1'b0, 1'b1);
    run_until_frames(BF * BT + 1, "s2b");
    check_int("s2_fail_never", sf_high, 0);
    check1("s2_success_seen", ss_high > 0, 1'b1);

    // Scenario 3: held button, early press, valid press.
    do_reset(); clear_stats();
    pulse(1'b1, 1'b0);
    run_until_frames(BF * BT - 2, "s3a");
    bus.btn_restart = 1'b1;
    run_until_frames(BF * BT, "s3b");
    run(8);
    check_int("s3_held_no_restart", rs_pulses, 0);
    bus.btn_restart = 1'b0;
    run_until_frames(BF * BT + 1, "s3c");
    run(4);
    press_restart();
    check_int("s3_early_no_restart", rs_pulses, 0);
    run_until_frames(BF * BT + HM, "s3d");
    run(4);
    press_restart();
    check_int("s3_restart_one_clk", rs_pulses, 1);
    check1("s3_busy_after", bus.busy, 1'b0);
    check1("s3_success_after", bus.show_success, 1'b0);

    // Scenario 4: lose sequence, restart, then a clean win.
    clear_stats();
    pulse(1'b0, 1'b1);
    run_until_frames(BF * BT + HM, "s4a");
    check_int("s4_fail_first_on_len", fall_cyc - rise_cyc, BF * FRAME_LEN);
    run(4);
    press_restart();
    check_int("s4_restart", rs_pulses, 1);
    check_int("s4_success_never", ss_high, 0);
    check1("s4_idle", bus.busy, 1'b0);
    clear_stats();
    pulse(1'b1, 1'b0);
    run_until_frames(BF * BT + 1, "s4b");
    check_int("s4_win_first_on_len", fall_cyc - rise_cyc, BF * FRAME_LEN);
    check_int("s4_win_fail_never", sf_high, 0);

    // Scenario 5: reset while the splash is visible.
    do_reset(); clear_stats();
    pulse(1'b1, 1'b0);
    run_until_frames(0, "s5a");
    run(10);
    check1("s5_visible", bus.show_success, 1'b1);
    do_reset();
    check1("s5_rst_ss", bus.show_success, 1'b0);
    check1("s5_rst_busy", bus.busy, 1'b0);
    check1("s5_rst_restart", bus.restart, 1'b0);
    run(2 * FRAME_LEN);
    check_int("s5_no_restart", rs_pulses, 0);
    check1("s5_still_idle", bus.busy, 1'b0);
    clear_stats();
    pulse(1'b1, 1'b0);
    run_until_frames(BF * BT + 1, "s5b");
    check_int("s5_first_on_len", fall_cyc - rise_cyc, BF * FRAME_LEN);

    // Scenario 6: origin held for 8 clk still yields one tick per frame.
    stretch = 1'b1;
    do_reset(); clear_stats();
    pulse(1'b1, 1'b0);
    run_until_frames(BF * BT + HM, "s6");
    check_int("s6_first_on_len", fall_cyc - rise_cyc, BF * (FRAME_LEN + PIX_CLK));
    run(4);
    press_restart();
    check_int("s6_restart", rs_pulses, 1);
    stretch = 1'b0;

    // Random traffic against the reference model.
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      bus.win  = ($urandom_range(0, 299) == 0);
      bus.lose = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) bus.btn_restart = ~bus.btn_restart;
      reset = ($urandom_range(0, 1999) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
